// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch-side lookup is purely combinational. The EX stage resolves the branch,
// raises flush on a wrong prediction, and trains the table on the next rising
// clock edge. A saturating counter tracks how many mispredicts have occurred.

module branch_predict_unit #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned IDX_W    = 4,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,

    // Fetch-stage lookup
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,

    // EX-stage resolve and update
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_branch,
    input  logic [3:0]  ex_flags,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,

    // Mispredict recovery
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [15:0] mispred_cnt
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    // Branch codes carried down the pipeline from decode.
    typedef enum logic [3:0] {
        BR_JALR = 4'b0001,
        BR_BEQ  = 4'b0010,
        BR_BLT  = 4'b0011,
        BR_BNE  = 4'b0100,
        BR_BGE  = 4'b0101,
        BR_BLTU = 4'b0110,
        BR_BGEU = 4'b0111,
        BR_JAL  = 4'b1000
    } br_code_e;

    // ALU flag positions inside ex_flags = {of, cf, sf, zf}; of is not needed.
    localparam int unsigned FLAG_ZF = 0;
    localparam int unsigned FLAG_SF = 1;
    localparam int unsigned FLAG_CF = 2;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_uncond;
    logic [1:0]         r_cnt    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [15:0]        r_mispred_cnt;

    // ------------------------------------------------------------------
    // Address decomposition
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[31:IDX_W+2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[31:IDX_W+2];

    // Byte-offset PC bits and the overflow flag play no part in prediction.
    logic w_unused_bits;
    assign w_unused_bits = ^{if_pc[1:0], ex_pc[1:0], ex_flags[3]};

    // ------------------------------------------------------------------
    // Fetch lookup
    // ------------------------------------------------------------------
    logic w_if_hit;

    // Combinational lookup; reads the table as it stood before this edge's update.
    always_comb begin
        w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
        pred_taken  = w_if_hit && (r_uncond[w_if_idx] || r_cnt[w_if_idx][1]);
        pred_target = w_if_hit ? r_target[w_if_idx] : (if_pc + 32'd4);
    end

    // ------------------------------------------------------------------
    // EX resolve
    // ------------------------------------------------------------------
    logic w_is_branch;
    logic w_is_uncond;
    logic w_taken;

    // Decode the branch code and evaluate its condition against the ALU flags.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        w_is_branch = 1'b0;
        w_is_uncond = 1'b0;
        w_taken     = 1'b0;
        case (ex_branch)
            BR_JAL, BR_JALR: begin
                w_is_branch = 1'b1;
                w_is_uncond = 1'b1;
                w_taken     = 1'b1;
            end
            BR_BEQ: begin
                w_is_branch = 1'b1;
                w_taken     = ex_flags[FLAG_ZF];
            end
            BR_BNE: begin
                w_is_branch = 1'b1;
                w_taken     = ~ex_flags[FLAG_ZF];
            end
            BR_BLT: begin
                w_is_branch = 1'b1;
                w_taken     = ex_flags[FLAG_SF];
            end
            BR_BGE: begin
                w_is_branch = 1'b1;
                w_taken     = ~ex_flags[FLAG_SF];
            end
            BR_BLTU: begin
                w_is_branch = 1'b1;
                w_taken     = ex_flags[FLAG_CF];
            end
            BR_BGEU: begin
                w_is_branch = 1'b1;
                w_taken     = ~ex_flags[FLAG_CF];
            end
            default: begin
                w_is_branch = 1'b0;
                w_is_uncond = 1'b0;
                w_taken     = 1'b0;
            end
        endcase
    end

    // Compare the resolved outcome with what fetch assumed and pick the fix-up PC.
    always_comb begin
        flush       = ex_valid &&
                      ((w_taken != ex_pred_taken) ||
                       (w_taken && (ex_pred_target != ex_target)));
        redirect_pc = w_taken ? ex_target : (ex_pc + 32'd4);
    end

    // ------------------------------------------------------------------
    // Table update
    // ------------------------------------------------------------------
    logic w_upd;
    logic w_ex_hit;

    assign w_upd    = ex_valid && w_is_branch;
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    // Control state: valid, direction counter and unconditional flag per entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // flop samples its inputs from before the edge.
                r_valid[i]  <= 1'b0;
                r_uncond[i] <= 1'b0;
                r_cnt[i]    <= CNT_INIT;
            end
        end else if (w_upd) begin
            if (w_ex_hit) begin
                // Jumps keep their counter; only conditional branches train it.
                if (!w_is_uncond) begin
                    if (w_taken && (r_cnt[w_ex_idx] != 2'b11)) begin
                        r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + 2'd1;
                    end else if (!w_taken && (r_cnt[w_ex_idx] != 2'b00)) begin
                        r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - 2'd1;
                    end
                end
            end else if (w_taken) begin
                // Allocate (or evict an alias) only for branches actually taken.
                r_valid[w_ex_idx]  <= 1'b1;
                r_uncond[w_ex_idx] <= w_is_uncond;
                r_cnt[w_ex_idx]    <= 2'b10;
            end
        end
    end

    // Payload: tag and target, written whenever a valid branch is taken.
    always_ff @(posedge clk) begin
        // NOTE: tag and target arrays are deliberately not reset; they are only
        // ever observed through a set valid bit, which reset does clear.
        if (w_upd && w_taken) begin
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= ex_target;
        end
    end

    // ------------------------------------------------------------------
    // Mispredict counter
    // ------------------------------------------------------------------

    // Count every edge that sees a flush, sticking at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispred_cnt <= 16'h0000;
        end else if (flush && (r_mispred_cnt != 16'hFFFF)) begin
            r_mispred_cnt <= r_mispred_cnt + 16'd1;
        end
    end

    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit
// Directed bench for branch_predict_unit with hand-computed expectations.

module tb_branch_predict_unit;

    localparam logic [3:0] C_JALR = 4'b0001;
    localparam logic [3:0] C_BEQ  = 4'b0010;
    localparam logic [3:0] C_BLT  = 4'b0011;
    localparam logic [3:0] C_BNE  = 4'b0100;
    localparam logic [3:0] C_BGE  = 4'b0101;
    localparam logic [3:0] C_BLTU = 4'b0110;
    localparam logic [3:0] C_BGEU = 4'b0111;
    localparam logic [3:0] C_JAL  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_branch;
    logic [3:0]  ex_flags;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [15:0] mispred_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .ENTRIES  (16),
        .IDX_W    (4),
        .CNT_INIT (2'b01)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_branch      (ex_branch),
        .ex_flags       (ex_flags),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .mispred_cnt    (mispred_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid       = 1'b0;
        ex_pc          = 32'h0;
        ex_branch      = 4'h0;
        ex_flags       = 4'h0;
        ex_target      = 32'h0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [3:0] code, input logic [3:0] flags,
                         input logic [31:0] tgt, input logic ept, input logic [31:0] eptgt);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_branch      = code;
        ex_flags       = flags;
        ex_target      = tgt;
        ex_pred_taken  = ept;
        ex_pred_target = eptgt;
        #1;
    endtask

    // Drive one EX instruction, check flush/redirect, clock it in, go idle.
    task automatic resolve(input string tag, input logic [31:0] pc, input logic [3:0] code,
                           input logic [3:0] flags, input logic [31:0] tgt, input logic ept,
                           input logic [31:0] eptgt, input logic exp_flush,
                           input logic [31:0] exp_redir);
        drive(pc, code, flags, tgt, ept, eptgt);
        check({tag, "_flush"}, 32'(flush), 32'(exp_flush));
        if (exp_flush) check({tag, "_redir"}, redirect_pc, exp_redir);
        tick();
        idle();
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_pt,
                        input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({tag, "_pt"}, 32'(pred_taken), 32'(exp_pt));
        check({tag, "_tgt"}, pred_target, exp_tgt);
    endtask

    task automatic chk_mis(input string tag, input logic [15:0] exp);
        check(tag, 32'(mispred_cnt), 32'(exp));
    endtask

    // Resolve-only vectors: evaluated combinationally, never clocked in.
    localparam int N_RV = 17;
    logic [3:0] rv_code  [N_RV] = '{C_JAL, C_JALR, C_BEQ, C_BEQ, C_BNE, C_BNE, C_BLT, C_BLT,
                                    C_BGE, C_BGE, C_BLTU, C_BLTU, C_BGEU, C_BGEU,
                                    4'b1111, 4'b0000, 4'b1001};
    logic [3:0] rv_flags [N_RV] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000,
                                    4'b0010, 4'b0000, 4'b0010, 4'b1101, 4'b0100, 4'b1011,
                                    4'b0100, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    logic       rv_taken [N_RV] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                    1'b0, 1'b0, 1'b0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100;
        idle();

        // Reset state
        #3;
        look("rst_lookup", 32'h100, 1'b0, 32'h104);
        chk_mis("rst_mis", 16'h0);
        check("rst_flush", 32'(flush), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        look("post_rst_lookup", 32'h100, 1'b0, 32'h104);

        // First taken beq allocates; same-cycle lookup sees the old (empty) entry
        if_pc = 32'h100;
        drive(32'h100, C_BEQ, 4'b0001, 32'h140, 1'b0, 32'h0);
        check("t1_flush", 32'(flush), 32'd1);
        check("t1_redir", redirect_pc, 32'h140);
        check("t1_nobypass", 32'(pred_taken), 32'd0);
        tick();
        idle();
        chk_mis("t1_mis", 16'd1);
        look("t1_lookup", 32'h100, 1'b1, 32'h140);

        // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
        resolve("ntA", 32'h100, C_BEQ, 4'b0000, 32'h140, 1'b1, 32'h140, 1'b1, 32'h104);
        chk_mis("ntA_mis", 16'd2);
        look("ntA_lookup", 32'h100, 1'b0, 32'h140);
        resolve("ntB", 32'h100, C_BEQ, 4'b0000, 32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
        look("ntB_lookup", 32'h100, 1'b0, 32'h140);
        resolve("ntC", 32'h100, C_BEQ, 4'b0000, 32'h140, 1'b0, 32'h0, 1'b0, 32'h0);
        look("ntC_lookup", 32'h100, 1'b0, 32'h140);
        chk_mis("ntC_mis", 16'd2);
        resolve("tkD", 32'h100, C_BEQ, 4'b0001, 32'h140, 1'b0, 32'h0, 1'b1, 32'h140);
        look("tkD_lookup", 32'h100, 1'b0, 32'h140);
        resolve("tkE", 32'h100, C_BEQ, 4'b0001, 32'h140, 1'b0, 32'h0, 1'b1, 32'h140);
        look("tkE_lookup", 32'h100, 1'b1, 32'h140);
        resolve("tkF", 32'h100, C_BEQ, 4'b0001, 32'h140, 1'b1, 32'h140, 1'b0, 32'h0);
        resolve("tkG", 32'h100, C_BEQ, 4'b0001, 32'h140, 1'b1, 32'h140, 1'b0, 32'h0);
        resolve("ntH", 32'h100, C_BEQ, 4'b0000, 32'h140, 1'b1, 32'h140, 1'b1, 32'h104);
        look("ntH_lookup", 32'h100, 1'b1, 32'h140);
        chk_mis("ntH_mis", 16'd5);

        // Not-taken bltu that misses: no allocation, aliasing entry untouched
        resolve("bltu", 32'h180, C_BLTU, 4'b0000, 32'h1C0, 1'b0, 32'h0, 1'b0, 32'h0);
        look("bltu_keep", 32'h100, 1'b1, 32'h140);
        look("bltu_miss", 32'h180, 1'b0, 32'h184);
        chk_mis("bltu_mis", 16'd5);

        // jalr retargeting
        resolve("jalr1", 32'h200, C_JALR, 4'b0000, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
        look("jalr1_lookup", 32'h200, 1'b1, 32'h300);
        look("jalr1_evict", 32'h100, 1'b0, 32'h104);
        resolve("jalr2", 32'h200, C_JALR, 4'b0000, 32'h380, 1'b1, 32'h300, 1'b1, 32'h380);
        look("jalr2_lookup", 32'h200, 1'b1, 32'h380);
        chk_mis("jalr2_mis", 16'd7);

        // Correctly predicted jal allocates silently
        resolve("jal", 32'h204, C_JAL, 4'b0000, 32'h400, 1'b1, 32'h400, 1'b0, 32'h0);
        look("jal_lookup", 32'h204, 1'b1, 32'h400);

        // Alias on index 0: 0x140 replaces 0x100
        resolve("al100", 32'h100, C_BEQ, 4'b0001, 32'h140, 1'b0, 32'h0, 1'b1, 32'h140);
        resolve("al140", 32'h140, C_BEQ, 4'b0001, 32'h180, 1'b0, 32'h0, 1'b1, 32'h180);
        look("alias_miss", 32'h100, 1'b0, 32'h104);
        look("alias_hit", 32'h140, 1'b1, 32'h180);
        look("alias_jal", 32'h204, 1'b1, 32'h400);
        chk_mis("alias_mis", 16'd9);

        // Resolve table for every code, combinational only
        for (int i = 0; i < N_RV; i++) begin
            @(negedge clk);
            drive(32'h800, rv_code[i], rv_flags[i], 32'h900, 1'b1, 32'h900);
            check($sformatf("rv%0d_flush", i), 32'(flush), 32'(!rv_taken[i]));
            if (!rv_taken[i]) check($sformatf("rv%0d_redir", i), redirect_pc, 32'h804);
            idle();
        end

        // Wrap of ex_pc+4, and no flush without ex_valid
        @(negedge clk);
        drive(32'hFFFF_FFFC, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0);
        check("wrap_flush", 32'(flush), 32'd1);
        check("wrap_redir", redirect_pc, 32'h0);
        ex_valid = 1'b0;
        #1;
        check("novalid_flush", 32'(flush), 32'd0);
        idle();
        tick();
        chk_mis("wrap_mis", 16'd9);

        // Saturation of the mispredict counter
        drive(32'h700, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0);
        repeat (65536) tick();
        chk_mis("sat_mis", 16'hFFFF);
        tick();
        chk_mis("sat_hold", 16'hFFFF);

        // Asynchronous reset while a jal update is pending
        drive(32'h140, C_JAL, 4'b0000, 32'h500, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk_mis("arst_mis", 16'h0);
        tick();
        look("arst_140", 32'h140, 1'b0, 32'h144);
        look("arst_204", 32'h204, 1'b0, 32'h208);
        #2;
        rst_n = 1'b1;
        idle();
        tick();
        look("after_140", 32'h140, 1'b0, 32'h144);
        chk_mis("after_mis", 16'h0);

        // Table trains again after reset
        resolve("retrain", 32'h100, C_BEQ, 4'b0001, 32'h140, 1'b0, 32'h0, 1'b1, 32'h140);
        look("retrain_lookup", 32'h100, 1'b1, 32'h140);
        chk_mis("retrain_mis", 16'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter ENTRIES, default 16, number of predictor entries; power of two, 4..256.
REQ-002 Parameter IDX_W, default 4, equal to log2(ENTRIES).
REQ-003 Parameter CNT_INIT, default 2'b01, reset value of every 2-bit counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 if_pc  input  32  fetch-stage PC being looked up.
REQ-007 pred_taken  output  1  fetch-stage prediction: redirect to pred_target.
REQ-008 pred_target  output  32  predicted target for if_pc.
REQ-009 ex_valid  input  1  EX-stage instruction valid.
REQ-010 ex_pc  input  32  PC of the EX-stage instruction.
REQ-011 ex_branch  input  4  branch code: 1000 jal, 0001 jalr, 0010 beq, 0100 bne, 0011 blt, 0101 bge, 0110 bltu, 0111 bgeu; any other value is a non-branch.
REQ-012 ex_flags  input  4  ALU flags {of,cf,sf,zf}, bit0 = zf.
REQ-013 ex_target  input  32  computed taken target of the EX instruction.
REQ-014 ex_pred_taken, ex_pred_target  input  1/32  prediction carried down the pipeline with the EX instruction.
REQ-015 flush  output  1  mispredict: squash IF/ID and redirect fetch.
REQ-016 redirect_pc  output  32  correct next PC while flush=1.
REQ-017 mispred_cnt  output  16  saturating mispredict count.

Function
REQ-018 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; each entry holds valid, tag, 2-bit counter, uncond bit, 32-bit target.
REQ-019 Lookup is combinational: hit = valid & tag match; pred_taken = hit & (uncond | counter[1]); pred_target = entry target if hit, else if_pc+4.
REQ-020 Resolve is combinational: jal, jalr taken; beq zf; bne ~zf; blt sf; bge ~sf; bltu cf; bgeu ~cf; non-branch not taken.
REQ-021 flush = ex_valid & ((taken != ex_pred_taken) | (taken & ex_pred_target != ex_target)); flush = 0 when ex_valid = 0.
REQ-022 redirect_pc = ex_target when taken, else ex_pc+4 (32-bit wrap); don't-care while flush=0.
REQ-023 Update on the rising edge when ex_valid = 1 and ex_branch is a branch code; no update for non-branch codes.
REQ-024 Hit update: conditional counter +1 on taken, saturating at 3; -1 on not taken, saturating at 0; target := ex_target when taken.
REQ-025 Miss, taken: allocate/replace entry, valid = 1, tag written, target = ex_target, counter = 2'b10, uncond = 1 for jal/jalr and 0 otherwise.
REQ-026 Miss, not taken: no table write.
REQ-027 jal/jalr hit: counter unchanged, target rewritten with ex_target each time.
REQ-028 Same-cycle lookup and update to the same index: lookup returns the pre-update entry (no bypass).
REQ-029 mispred_cnt increments by 1 on each clock edge with flush = 1; holds at 16'hFFFF.

Reset
REQ-030 rst_n low clears all valid bits, sets all counters to CNT_INIT, clears uncond bits and mispred_cnt immediately, independent of clk.
REQ-031 During and after reset until the first update: pred_taken = 0, pred_target = if_pc+4.
REQ-032 Reset asserted mid-update: that update is discarded and the table reads as freshly reset.

Verification
REQ-033 Reset, then ex_valid=1, ex_pc=0x100, beq, zf=1, ex_target=0x140, ex_pred_taken=0 -> flush=1, redirect_pc=0x140, mispred_cnt=1; next cycle, if_pc=0x100 -> pred_taken=1, pred_target=0x140.
REQ-034 Same beq resolved not-taken twice (zf=0) -> counter 10->01->00; if_pc=0x100 -> pred_taken=0 after the first not-taken.
REQ-035 bltu with cf=0, ex_pred_taken=0 -> flush=0, no table write; hit entry unchanged.
REQ-036 jalr at 0x200 resolved to 0x300, then 0x380 with ex_pred_target=0x300 -> second resolve flush=1, redirect_pc=0x380; lookup 0x200 then gives 0x380.
REQ-037 Alias: ENTRIES=16, entries at 0x100 and 0x140 share index 0 -> 0x140 replaces 0x100; lookup 0x100 misses, pred_taken=0.
REQ-038 Force 65536 consecutive mispredicts -> mispred_cnt saturates at 0xFFFF; rst_n pulse mid-run -> counter 0, all lookups miss.
